// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sprite helpers used by the renderer.
package vga_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned SPR_W        = 32;
  localparam int unsigned SPR_H        = 32;
  localparam int unsigned FLASH_FRAMES = 8;
  localparam int unsigned COLOR_W      = 3;
  localparam int unsigned FLASH_W      = 4;
  // First blanking row; its column 0 is the once-per-frame update point.
  localparam int unsigned TICK_ROW     = V_ACTIVE;
  localparam int unsigned X_MAX        = H_ACTIVE - SPR_W;
  localparam int unsigned Y_MAX        = V_ACTIVE - SPR_H;

  typedef enum logic {DirPos, DirNeg} dir_e;

  // Colour index cycles 1..7 and never lands on black (0).
  function automatic logic [COLOR_W-1:0] next_color(input logic [COLOR_W-1:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/sprite_bounce_renderer_if.sv
// Pixel-stage bundle: generator timing/controls in, colour and re-timed syncs out.
interface sprite_bounce_renderer_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] speed_sel;
  logic       pause;
  logic [1:0] R;
  logic [1:0] G;
  logic [1:0] B;
  logic       hsync_out;
  logic       vsync_out;
  logic       bounce;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in, speed_sel, pause,
    input  R, G, B, hsync_out, vsync_out, bounce
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in, speed_sel, pause,
    output R, G, B, hsync_out, vsync_out, bounce
  );
endinterface

// File: rtl/sprite_bounce_renderer_axis.sv
// One axis of sprite motion: position, direction and wall-hit detection.
module sprite_axis_mover
  import vga_pkg::*;
#(
  parameter int unsigned Max  = 608,
  parameter int unsigned Init = 304
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic [2:0] step,
  output logic [9:0] pos,
  output dir_e       dir,
  output logic       hit
);

  localparam logic signed [10:0] MaxS = 11'(Max);

  logic [9:0]        pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic signed [10:0] n;

  // Candidate position and wall clamping; hit only when a move actually happens.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    hit   = 1'b0;
    if (dir_q == DirNeg) n = $signed({1'b0, pos_q}) - $signed({8'b0, step});
    else                 n = $signed({1'b0, pos_q}) + $signed({8'b0, step});
    if (tick && !pause) begin
      if (n <= 11'sd0) begin
        pos_d = '0;
        dir_d = DirPos;
        hit   = 1'b1;
      end else if (n >= MaxS) begin
        pos_d = 10'(Max);
        dir_d = DirNeg;
        hit   = 1'b1;
      end else begin
        pos_d = n[9:0];
      end
    end
  end

  // Axis state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= 10'(Init);
      dir_q <= DirPos;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/sprite_bounce_renderer.sv
// Bouncing-sprite pixel stage: moves the sprite once per frame, renders colour with 1-clk latency.
module sprite_bounce_renderer
  import vga_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  sprite_bounce_renderer_if.slave  bus
);

  logic [9:0]         x_pos, y_pos;
  dir_e               x_dir, y_dir;
  logic               hit_x, hit_y, hit_any, tick, in_spr;
  logic [2:0]         step;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic [5:0]         rgb_d;

  assign tick    = (bus.hpos == 10'd0) && (bus.vpos == 10'(TICK_ROW));
  assign step    = {1'b0, bus.speed_sel} + 3'd1;
  assign hit_any = hit_x | hit_y;

  sprite_axis_mover #(.Max(X_MAX), .Init(X_MAX / 2)) u_x (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pause (bus.pause),
    .step  (step),
    .pos   (x_pos),
    .dir   (x_dir),
    .hit   (hit_x)
  );

  sprite_axis_mover #(.Max(Y_MAX), .Init(Y_MAX / 2)) u_y (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .pause (bus.pause),
    .step  (step),
    .pos   (y_pos),
    .dir   (y_dir),
    .hit   (hit_y)
  );

  // Colour/flash bookkeeping plus the combinational pixel colour.
  always_comb begin
    color_d = color_q;
    flash_d = flash_q;
    if (tick) begin
      if (hit_any) begin
        // A corner hit is one event: single colour advance.
        color_d = next_color(color_q);
        flash_d = FLASH_W'(FLASH_FRAMES);
      end else if (flash_q != '0) begin
        flash_d = flash_q - 1'b1;
      end
    end
    in_spr = bus.display_on
             && ({1'b0, bus.hpos} >= {1'b0, x_pos})
             && ({1'b0, bus.hpos} <  {1'b0, x_pos} + 11'(SPR_W))
             && ({1'b0, bus.vpos} >= {1'b0, y_pos})
             && ({1'b0, bus.vpos} <  {1'b0, y_pos} + 11'(SPR_H));
    rgb_d = '0;
    if (in_spr) begin
      if (flash_q != '0) rgb_d = 6'h3f;
      else rgb_d = {{2{color_q[0]}}, {2{color_q[1]}}, {2{color_q[2]}}};
    end
  end

  // State and output registers; syncs share the colour's 1-clk delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      color_q       <= 3'd1;
      flash_q       <= '0;
      bus.R         <= '0;
      bus.G         <= '0;
      bus.B         <= '0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
      bus.bounce    <= 1'b0;
    end else begin
      color_q       <= color_d;
      flash_q       <= flash_d;
      bus.R         <= rgb_d[5:4];
      bus.G         <= rgb_d[3:2];
      bus.B         <= rgb_d[1:0];
      bus.hsync_out <= bus.hsync_in;
      bus.vsync_out <= bus.vsync_in;
      bus.bounce    <= tick & hit_any;
    end
  end

endmodule

// File: tb/tb_sprite_bounce_renderer.sv
// Randomized bench for the bouncing-sprite renderer against a frame-level model.
module tb_sprite_bounce_renderer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sprite_bounce_renderer_if bus ();

  sprite_bounce_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_x, m_y, m_dx, m_dy, m_color, m_flash;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = 304; m_y = 224; m_dx = 1; m_dy = 1; m_color = 1; m_flash = 0;
  endtask

  // One axis move: returns hit.
  function automatic bit move(inout int p, inout int d, input int st, input int mx);
    int n;
    n = p + d * st;
    if (n <= 0) begin p = 0; d = 1; return 1; end
    if (n >= mx) begin p = mx; d = -1; return 1; end
    p = n;
    return 0;
  endfunction

  function automatic bit model_tick(input int sel, input bit pz);
    bit hx, hy;
    hx = 0; hy = 0;
    if (!pz) begin
      hx = move(m_x, m_dx, sel + 1, 608);
      hy = move(m_y, m_dy, sel + 1, 448);
    end
    if (hx || hy) begin
      m_color = (m_color == 7) ? 1 : m_color + 1;
      m_flash = 8;
    end else if (m_flash > 0) begin
      m_flash--;
    end
    return hx || hy;
  endfunction

  function automatic int exp_rgb(input int h, input int v, input bit disp);
    int c;
    if (!(disp && h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32)) return 0;
    if (m_flash != 0) return 6'h3f;
    c = m_color;
    return ((c & 1) ? 6'h30 : 0) | ((c & 2) ? 6'h0c : 0) | ((c & 4) ? 6'h03 : 0);
  endfunction

  function automatic int obs_out();
    return {bus.R, bus.G, bus.B, bus.hsync_out, bus.vsync_out, bus.bounce};
  endfunction

  task automatic do_tick(input int sel, input bit pz);
    bit hit;
    bus.hpos = 10'd0; bus.vpos = 10'd480; bus.display_on = 1'b0;
    bus.speed_sel = 2'(sel); bus.pause = pz;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b1;
    step();
    hit = model_tick(sel, pz);
    check_eq("bounce_at_tick", int'(bus.bounce), int'(hit));
    check_eq("vsync_delay", int'(bus.vsync_out), 1);
    check_eq("x_pos", int'(dut.x_pos), m_x);
    check_eq("y_pos", int'(dut.y_pos), m_y);
    check_eq("color_idx", int'(dut.color_q), m_color);
  endtask

  task automatic do_pixel(input int h, input int v, input bit disp);
    bit hs, vs;
    hs = 1'($urandom); vs = 1'($urandom);
    if (h == 0 && v == 480) v = 479;
    bus.hpos = 10'(h); bus.vpos = 10'(v); bus.display_on = disp;
    bus.hsync_in = hs; bus.vsync_in = vs;
    step();
    check_eq("pixel", obs_out(), (exp_rgb(h, v, disp) << 3) | (int'(hs) << 2) | (int'(vs) << 1));
  endtask

  task automatic rand_pixels(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int h, v;
      h = m_x - 4 + int'($urandom_range(0, 40));
      v = m_y - 4 + int'($urandom_range(0, 40));
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      do_pixel(h, v, ($urandom_range(0, 7) != 0));
    end
  endtask

  initial begin
    bus.hpos = '0; bus.vpos = '0; bus.display_on = 1'b0; bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0; bus.speed_sel = '0; bus.pause = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    model_reset();
    check_eq("reset_outputs", obs_out(), 0);
    check_eq("reset_x", int'(dut.x_pos), 304);
    check_eq("reset_y", int'(dut.y_pos), 224);
    check_eq("reset_color", int'(dut.color_q), 1);

    // First frame at slowest speed, then render probes around the sprite's corner.
    do_tick(0, 1'b0);
    check_eq("first_x", m_x, 305);
    do_pixel(305, 225, 1'b1);
    do_pixel(337, 225, 1'b1);
    do_pixel(305, 225, 1'b0);
    do_pixel(304, 225, 1'b1);
    do_pixel(336, 256, 1'b1);

    // Fast run from reset to the bottom and right walls.
    reset = 1'b1; step(); reset = 1'b0; model_reset();
    for (int f = 0; f < 80; f++) begin
      do_tick(3, 1'b0);
      rand_pixels(2);
    end

    // Paused frames: position frozen, flash drains.
    for (int f = 0; f < 10; f++) begin
      do_tick(3, 1'b1);
      rand_pixels(1);
    end

    // Random speeds and pauses; many bounces exercise the 7 -> 1 colour wrap.
    for (int f = 0; f < 400; f++) begin
      do_tick(int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
      rand_pixels(2);
    end

    // Reset mid visible line, with an in-sprite pixel and high syncs on the inputs.
    bus.hpos = 10'(m_x + 1); bus.vpos = 10'(m_y + 1); bus.display_on = 1'b1;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    reset = 1'b1;
    step();
    model_reset();
    check_eq("midline_reset_outputs", obs_out(), 0);
    check_eq("midline_reset_x", int'(dut.x_pos), 304);
    check_eq("midline_reset_y", int'(dut.y_pos), 224);
    check_eq("midline_reset_color", int'(dut.color_q), 1);
    reset = 1'b0;
    do_pixel(310, 230, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
